// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the pipeline hazard unit: FSM states and EX operand
// forwarding selects.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_REDIRECT = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // Wide enough for the largest legal instruction-memory latency (3).
  localparam int CNT_W = 2;

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// EX operand forwarding select for one source register. This module is only
// built when HAZARD_FORWARD_EN is defined.
`ifdef HAZARD_FORWARD_EN
module hazard_fwd_sel
  import hazard_unit_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] mem_rd_i,
  input  logic             mem_regwen_i,
  input  logic [REG_W-1:0] wb_rd_i,
  input  logic             wb_regwen_i,
  output fwd_sel_e         sel_o
);

  // MEM holds the younger result, so it wins over WB. x0 never forwards.
  always_comb begin
    sel_o = FWD_RF;
    if (rs_i != '0) begin
      if (mem_regwen_i && (mem_rd_i == rs_i)) begin
        sel_o = FWD_MEM;
      end else if (wb_regwen_i && (wb_rd_i == rs_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule
`endif

// File: rtl/hazard_unit.sv
// Pipeline sequencing controller for the 5-stage RV32I core: stalls, redirect
// squashes and data-memory freezes. Define HAZARD_FORWARD_EN to enable forwarding.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int IMEM_LAT = 1,
  parameter int REG_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [REG_W-1:0] ex_rs1_i,
  input  logic [REG_W-1:0] ex_rs2_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_regwen_i,
  input  logic             ex_is_load_i,
  input  logic [REG_W-1:0] mem_rd_i,
  input  logic             mem_regwen_i,
  input  logic [REG_W-1:0] wb_rd_i,
  input  logic             wb_regwen_i,
  input  logic             ex_redirect_i,
  input  logic             mem_access_i,
  input  logic             dmem_ready_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             pipe_en_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [1:0]       state_o
);

  hz_state_e        state_q, state_d;
  hz_state_e        saved_q, saved_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic frozen, stall;
  logic pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush;
  hz_state_e eff_state;

  function automatic logic raw_match(input logic             use_rs,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rd,
                                     input logic             regwen);
    return use_rs && regwen && (rs == rd) && (rd != '0);
  endfunction

  function automatic logic id_matches(input logic [REG_W-1:0] rd,
                                      input logic             regwen);
    return raw_match(id_use_rs1_i, id_rs1_i, rd, regwen) ||
           raw_match(id_use_rs2_i, id_rs2_i, rd, regwen);
  endfunction

`ifdef HAZARD_FORWARD_EN
  fwd_sel_e fwd_a, fwd_b;

  // Forwarding covers every RAW except a load still in EX.
  assign stall = ex_is_load_i && id_matches(ex_rd_i, ex_regwen_i);

  hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
    .rs_i        (ex_rs1_i),
    .mem_rd_i    (mem_rd_i),
    .mem_regwen_i(mem_regwen_i),
    .wb_rd_i     (wb_rd_i),
    .wb_regwen_i (wb_regwen_i),
    .sel_o       (fwd_a)
  );

  hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
    .rs_i        (ex_rs2_i),
    .mem_rd_i    (mem_rd_i),
    .mem_regwen_i(mem_regwen_i),
    .wb_rd_i     (wb_rd_i),
    .wb_regwen_i (wb_regwen_i),
    .sel_o       (fwd_b)
  );

  assign fwd_a_o = rst_n ? fwd_a : FWD_RF;
  assign fwd_b_o = rst_n ? fwd_b : FWD_RF;
`else
  logic unused_fwd_inputs;

  // Without forwarding, the ID instruction waits until no in-flight producer
  // matches; the WB match covers the write-then-read regfile timing.
  assign stall = id_matches(ex_rd_i, ex_regwen_i) ||
                 id_matches(mem_rd_i, mem_regwen_i) ||
                 id_matches(wb_rd_i, wb_regwen_i);

  assign unused_fwd_inputs = ^{ex_rs1_i, ex_rs2_i, ex_is_load_i};
  assign fwd_a_o = FWD_RF;
  assign fwd_b_o = FWD_RF;
`endif

  assign frozen = mem_access_i && !dmem_ready_i;
  // The release cycle out of MEM_WAIT behaves as the state saved on entry.
  assign eff_state = (state_q == HZ_MEM_WAIT) ? saved_q : state_q;

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    pipe_en     = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    state_d     = eff_state;
    saved_d     = saved_q;
    cnt_d       = cnt_q;

    if (frozen) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      pipe_en  = 1'b0;
      state_d  = HZ_MEM_WAIT;
      if (state_q != HZ_MEM_WAIT) begin
        saved_d = state_q;
      end
    end else if (ex_redirect_i) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      cnt_d       = CNT_W'(IMEM_LAT);
      state_d     = HZ_REDIRECT;
    end else if (eff_state == HZ_REDIRECT) begin
      // Wrong-path fetches still in flight from instruction memory are squashed.
      if_id_flush = 1'b1;
      cnt_d       = cnt_q - 1'b1;
      if (cnt_d == '0) begin
        state_d = HZ_RUN;
      end
    end else if (stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HZ_RUN;
      saved_q <= HZ_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset forces the pipeline safe immediately, without waiting for a clock.
  assign pc_en_o       = rst_n && pc_en;
  assign if_id_en_o    = rst_n && if_id_en;
  assign pipe_en_o     = rst_n && pipe_en;
  assign if_id_flush_o = !rst_n || if_id_flush;
  assign id_ex_flush_o = !rst_n || id_ex_flush;
  assign state_o       = rst_n ? state_q : HZ_RUN;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (IMEM_LAT=1); expectations
// follow the HAZARD_FORWARD_EN build setting.
module tb_hazard_unit;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // {pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en}
  localparam logic [4:0] CTL_RUN    = 5'b11001;
  localparam logic [4:0] CTL_STALL  = 5'b00011;
  localparam logic [4:0] CTL_FREEZE = 5'b00000;
  localparam logic [4:0] CTL_REDIR  = 5'b11111;
  localparam logic [4:0] CTL_SQUASH = 5'b11101;
  localparam logic [4:0] CTL_RESET  = 5'b00110;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_regwen, ex_is_load, mem_regwen, wb_regwen;
  logic       ex_redirect, mem_access, dmem_ready;
  logic       pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en;
  logic [1:0] fwd_a, fwd_b, state;
  logic [4:0] ctl;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_unit #(.IMEM_LAT(1), .REG_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_use_rs1_i (id_use_rs1),
    .id_use_rs2_i (id_use_rs2),
    .ex_rs1_i     (ex_rs1),
    .ex_rs2_i     (ex_rs2),
    .ex_rd_i      (ex_rd),
    .ex_regwen_i  (ex_regwen),
    .ex_is_load_i (ex_is_load),
    .mem_rd_i     (mem_rd),
    .mem_regwen_i (mem_regwen),
    .wb_rd_i      (wb_rd),
    .wb_regwen_i  (wb_regwen),
    .ex_redirect_i(ex_redirect),
    .mem_access_i (mem_access),
    .dmem_ready_i (dmem_ready),
    .pc_en_o      (pc_en),
    .if_id_en_o   (if_id_en),
    .if_id_flush_o(if_id_flush),
    .id_ex_flush_o(id_ex_flush),
    .pipe_en_o    (pipe_en),
    .fwd_a_o      (fwd_a),
    .fwd_b_o      (fwd_b),
    .state_o      (state)
  );

  assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_regwen = 1'b0; ex_is_load = 1'b0;
    mem_rd = '0; mem_regwen = 1'b0; wb_rd = '0; wb_regwen = 1'b0;
    ex_redirect = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();

    // Reset values
    settle();
    check("rst_ctl", 8'(ctl), 8'(CTL_RESET));
    check("rst_state", 8'(state), 8'd0);
    check("rst_fwd", 8'({fwd_a, fwd_b}), 8'd0);
    rst_n = 1'b1;
    next();
    settle();
    check("idle_ctl", 8'(ctl), 8'(CTL_RUN));
    check("idle_state", 8'(state), 8'd0);
    next();

    // Load-use: lw x5,0(x1) in EX, add x6,x5,x2 in ID
    id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd2; id_use_rs2 = 1'b1;
    ex_rs1 = 5'd1; ex_rd = 5'd5; ex_regwen = 1'b1; ex_is_load = 1'b1;
    settle();
    check("lu_stall", 8'(ctl), 8'(CTL_STALL));
    check("lu_stall_fwd_a", 8'(fwd_a), 8'd0);
    next();
    ex_rs1 = '0; ex_rd = '0; ex_regwen = 1'b0; ex_is_load = 1'b0;
    mem_rd = 5'd5; mem_regwen = 1'b1;
    settle();
    check("lu_bubble2", 8'(ctl), FWD ? 8'(CTL_RUN) : 8'(CTL_STALL));
    next();
`ifdef HAZARD_FORWARD_EN
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rs1 = 5'd5; ex_rs2 = 5'd2; ex_rd = 5'd6; ex_regwen = 1'b1;
    mem_rd = '0; mem_regwen = 1'b0; wb_rd = 5'd5; wb_regwen = 1'b1;
    settle();
    check("lu_after_ctl", 8'(ctl), 8'(CTL_RUN));
    check("lu_after_fwd_a", 8'(fwd_a), 8'b10);
    check("lu_after_fwd_b", 8'(fwd_b), 8'b00);
    next();
`else
    mem_rd = '0; mem_regwen = 1'b0; wb_rd = 5'd5; wb_regwen = 1'b1;
    settle();
    check("lu_wb_stall", 8'(ctl), 8'(CTL_STALL));
    next();
    wb_regwen = 1'b0;
    settle();
    check("lu_release", 8'(ctl), 8'(CTL_RUN));
    next();
`endif
    idle();

    // x0 producer: addi x0,x0,1 then add x3,x0,x0
    ex_rd = 5'd0; ex_regwen = 1'b1;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    settle();
    check("x0_no_stall", 8'(ctl), 8'(CTL_RUN));
    next();
    idle();
    ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd3; ex_regwen = 1'b1;
    mem_rd = 5'd0; mem_regwen = 1'b1;
    settle();
    check("x0_ctl", 8'(ctl), 8'(CTL_RUN));
    check("x0_fwd", 8'({fwd_a, fwd_b}), 8'd0);
    next();
    idle();

    // RAW on x7 walking EX -> MEM -> WB while the consumer sits in ID
    id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    ex_rd = 5'd7; ex_regwen = 1'b1;
    settle();
    check("raw_ex", 8'(ctl), FWD ? 8'(CTL_RUN) : 8'(CTL_STALL));
    next();
    ex_regwen = 1'b0; mem_rd = 5'd7; mem_regwen = 1'b1;
    settle();
    check("raw_mem", 8'(ctl), FWD ? 8'(CTL_RUN) : 8'(CTL_STALL));
    next();
    mem_regwen = 1'b0; wb_rd = 5'd7; wb_regwen = 1'b1;
    settle();
    check("raw_wb", 8'(ctl), FWD ? 8'(CTL_RUN) : 8'(CTL_STALL));
    next();
    wb_regwen = 1'b0;
    settle();
    check("raw_clear", 8'(ctl), 8'(CTL_RUN));
    next();
    idle();

    // Forward priority
    mem_rd = 5'd7; mem_regwen = 1'b1; wb_rd = 5'd7; wb_regwen = 1'b1;
    ex_rs1 = 5'd7; ex_rs2 = 5'd7;
    settle();
    check("fwd_mem_over_wb_a", 8'(fwd_a), FWD ? 8'b01 : 8'b00);
    check("fwd_mem_over_wb_b", 8'(fwd_b), FWD ? 8'b01 : 8'b00);
    next();
    wb_rd = 5'd9; ex_rs1 = 5'd9;
    settle();
    check("fwd_wb_a", 8'(fwd_a), FWD ? 8'b10 : 8'b00);
    check("fwd_mem_b", 8'(fwd_b), FWD ? 8'b01 : 8'b00);
    next();
    mem_regwen = 1'b0; wb_rd = 5'd7; ex_rs1 = 5'd7;
    settle();
    check("fwd_wb_only", 8'(fwd_a), FWD ? 8'b10 : 8'b00);
    next();
    idle();

    // Redirect, IMEM_LAT=1
    ex_redirect = 1'b1;
    settle();
    check("redir_c0_ctl", 8'(ctl), 8'(CTL_REDIR));
    check("redir_c0_state", 8'(state), 8'd0);
    next();
    ex_redirect = 1'b0;
    settle();
    check("redir_c1_ctl", 8'(ctl), 8'(CTL_SQUASH));
    check("redir_c1_state", 8'(state), 8'd1);
    next();
    settle();
    check("redir_c2_ctl", 8'(ctl), 8'(CTL_RUN));
    check("redir_c2_state", 8'(state), 8'd0);
    next();

    // Memory wait of 3 cycles with a redirect pending throughout
    mem_access = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("mw_freeze%0d_ctl", i), 8'(ctl), 8'(CTL_FREEZE));
      check($sformatf("mw_freeze%0d_state", i), 8'(state), (i == 0) ? 8'd0 : 8'd2);
      next();
    end
    dmem_ready = 1'b1;
    settle();
    check("mw_release_ctl", 8'(ctl), 8'(CTL_REDIR));
    check("mw_release_state", 8'(state), 8'd2);
    next();
    mem_access = 1'b0; ex_redirect = 1'b0;
    settle();
    check("mw_squash_ctl", 8'(ctl), 8'(CTL_SQUASH));
    check("mw_squash_state", 8'(state), 8'd1);
    next();
    settle();
    check("mw_done_state", 8'(state), 8'd0);
    next();

    // Freeze during REDIRECT: squash count holds, state restored on release
    ex_redirect = 1'b1;
    settle();
    check("rf_redir_ctl", 8'(ctl), 8'(CTL_REDIR));
    next();
    ex_redirect = 1'b0; mem_access = 1'b1; dmem_ready = 1'b0;
    settle();
    check("rf_freeze_ctl", 8'(ctl), 8'(CTL_FREEZE));
    check("rf_freeze_state", 8'(state), 8'd1);
    next();
    dmem_ready = 1'b1;
    settle();
    check("rf_release_ctl", 8'(ctl), 8'(CTL_SQUASH));
    check("rf_release_state", 8'(state), 8'd2);
    next();
    mem_access = 1'b0;
    settle();
    check("rf_run_ctl", 8'(ctl), 8'(CTL_RUN));
    check("rf_run_state", 8'(state), 8'd0);
    next();

    // Reset asserted mid-squash
    ex_redirect = 1'b1;
    settle();
    next();
    ex_redirect = 1'b0;
    check("mr_in_redirect", 8'(state), 8'd1);
    rst_n = 1'b0;
    #1;
    check("mr_ctl", 8'(ctl), 8'(CTL_RESET));
    check("mr_state", 8'(state), 8'd0);
    settle();
    rst_n = 1'b1;
    next();
    settle();
    check("mr_after_state", 8'(state), 8'd0);
    check("mr_after_cnt", 8'(dut.cnt_q), 8'd0);
    check("mr_after_ctl", 8'(ctl), 8'(CTL_RUN));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
